// File: rtl/stack_calc_param.sv
// Push-down stack calculator driven by mode switches and two pushbuttons.
// Ports: clk, rst_n (sync, active low), mode, btn_l, btn_r, din ->
//   dout/daddr (display), count, empty, full, err (sticky).
module stack_calc_param #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       mode,
    input  logic             btn_l,
    input  logic             btn_r,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [AW-1:0]    daddr,
    output logic [AW:0]      count,
    output logic             empty,
    output logic             full,
    output logic             err
);

    typedef enum logic [3:0] {
        OP_NONE, OP_PUSH, OP_POP, OP_ADD, OP_SUB,
        OP_AND, OP_OR, OP_DUP, OP_SWAP,
        OP_CLR, OP_TOP, OP_INC, OP_DEC
    } op_t;

    localparam logic [AW:0] ONE  = (AW+1)'(1);
    localparam logic [AW:0] TWO  = (AW+1)'(2);
    localparam logic [AW:0] DMAX = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem     [DEPTH];
    logic [WIDTH-1:0] mem_nxt [DEPTH];

    logic [AW:0]      cnt;
    logic [AW:0]      cnt_nxt;
    logic [AW-1:0]    daddr_nxt;
    logic             err_nxt;
    logic             bl_q;
    logic             br_q;
    logic             ev_l;
    logic             ev_r;
    op_t              op;
    logic             two;
    logic [AW-1:0]    top_i;
    logic [AW-1:0]    sec_i;
    logic [AW-1:0]    new_i;
    logic [WIDTH-1:0] top_v;
    logic [WIDTH-1:0] sec_v;
    logic [WIDTH-1:0] alu;

    assign count = cnt;
    assign empty = (cnt == '0);
    assign full  = (cnt == DMAX);
    assign two   = (cnt >= TWO);

    // Indices wrap naturally; each is only used when its entry exists.
    assign top_i = AW'(cnt - ONE);
    assign sec_i = AW'(cnt - TWO);
    assign new_i = cnt[AW-1:0];
    assign top_v = mem[top_i];
    assign sec_v = mem[sec_i];

    assign ev_l = btn_l & ~bl_q;
    assign ev_r = btn_r & ~br_q;

    // Left button has priority when both rise together.
    always_comb begin
        op = OP_NONE;
        priority case (1'b1)
            ev_l: begin
                case (mode)
                    3'b000:  op = OP_POP;
                    3'b001:  op = OP_SUB;
                    3'b010:  op = OP_CLR;
                    3'b011:  op = OP_DEC;
                    3'b100:  op = OP_AND;
                    3'b101:  op = OP_DUP;
                    default: op = OP_NONE;
                endcase
            end
            ev_r: begin
                case (mode)
                    3'b000:  op = OP_PUSH;
                    3'b001:  op = OP_ADD;
                    3'b010:  op = OP_TOP;
                    3'b011:  op = OP_INC;
                    3'b100:  op = OP_OR;
                    3'b101:  op = OP_SWAP;
                    default: op = OP_NONE;
                endcase
            end
            default: op = OP_NONE;
        endcase
    end

    always_comb begin
        alu = top_v + sec_v;
        case (op)
            OP_SUB:  alu = top_v - sec_v;
            OP_AND:  alu = top_v & sec_v;
            OP_OR:   alu = top_v | sec_v;
            default: alu = top_v + sec_v;
        endcase
    end

    always_comb begin
        mem_nxt   = mem;
        cnt_nxt   = cnt;
        daddr_nxt = daddr;
        err_nxt   = err;
        case (op)
            OP_PUSH: begin
                if (!full) begin
                    mem_nxt[new_i] = din;
                    cnt_nxt        = cnt + ONE;
                    daddr_nxt      = new_i;
                end else begin
                    err_nxt = 1'b1;
                end
            end
            OP_POP: begin
                if (!empty) begin
                    cnt_nxt   = cnt - ONE;
                    daddr_nxt = two ? sec_i : '0;
                end else begin
                    err_nxt = 1'b1;
                end
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                if (two) begin
                    mem_nxt[sec_i] = alu;
                    cnt_nxt        = cnt - ONE;
                    daddr_nxt      = sec_i;
                end else begin
                    err_nxt = 1'b1;
                end
            end
            OP_DUP: begin
                if (!empty && !full) begin
                    mem_nxt[new_i] = top_v;
                    cnt_nxt        = cnt + ONE;
                    daddr_nxt      = new_i;
                end else begin
                    err_nxt = 1'b1;
                end
            end
            OP_SWAP: begin
                if (two) begin
                    mem_nxt[top_i] = sec_v;
                    mem_nxt[sec_i] = top_v;
                    daddr_nxt      = top_i;
                end else begin
                    err_nxt = 1'b1;
                end
            end
            OP_CLR: begin
                cnt_nxt   = '0;
                daddr_nxt = '0;
                err_nxt   = 1'b0;
            end
            OP_TOP: daddr_nxt = empty ? '0 : top_i;
            OP_INC: daddr_nxt = daddr + AW'(1);
            OP_DEC: daddr_nxt = daddr - AW'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt   <= '0;
            daddr <= '0;
            dout  <= '0;
            err   <= 1'b0;
            bl_q  <= 1'b0;
            br_q  <= 1'b0;
        end else begin
            cnt   <= cnt_nxt;
            daddr <= daddr_nxt;
            err   <= err_nxt;
            bl_q  <= btn_l;
            br_q  <= btn_r;
            // Display reads through this cycle's write.
            dout  <= (cnt_nxt == '0) ? '0 : mem_nxt[daddr_nxt];
        end
    end

    // Storage has no reset; writes are suppressed while reset is held.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= mem_nxt[i];
            end
        end
    end

endmodule
